// File: rtl/arb_mux_pkg.sv
// Shared arbitration constants and helpers for arb_mux and later arbitrated blocks.
package arb_mux_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic {
    ArbFixed = 1'b0,
    ArbRr    = 1'b1
  } arb_mode_e;

  // Wrap with an explicit compare so non-power-of-two channel counts work.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned m);
    return (idx == m - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Fixed-priority / round-robin arbiter; owns the round-robin pointer.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned M    = 4,
  parameter int unsigned MODE = ARB_RR,
  localparam int unsigned CW  = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [M-1:0]  req,
  input  logic          advance,
  output logic [M-1:0]  grant,
  output logic [CW-1:0] grant_idx
);

  logic [CW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned start;
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    start     = (MODE == ARB_RR) ? int'(ptr_q) : 0;
    for (int unsigned k = 0; k < M; k++) begin
      idx = start + k;
      if (idx >= M) idx = idx - M;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = CW'(wrap_inc(int'(grant_idx), M));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// M-channel valid/ready selector with arbitration and a one-entry registered output stage.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned M    = 4,
  parameter int unsigned MODE = ARB_RR,
  localparam int unsigned CW  = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
  output logic [N-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [N-1:0]  out_data_q;
  logic [CW-1:0] out_chan_q;
  logic          out_valid_q;
  logic [M-1:0]  grant;
  logic [CW-1:0] grant_idx;
  logic          load;
  logic          xfer;

  rr_arbiter #(
    .M    (M),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Register may refill in the same cycle it drains.
  always_comb begin
    load     = ~out_valid_q | out_ready;
    in_ready = rst ? '0 : (grant & {M{load}});
    xfer     = |(in_ready & in_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[int'(grant_idx)*N +: N];
      out_chan_q  <= grant_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Randomised bench comparing three arb_mux configurations against a behavioural model.
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic [3:0]  in_valid;
  logic [31:0] word [4];
  logic [127:0] in_data4;
  logic [95:0]  in_data3;

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  oc0, oc1, oc2;
  logic        ov0, ov1, ov2;

  logic [3:0]  g_rdy [3];
  logic [31:0] g_od  [3];
  logic [1:0]  g_oc  [3];
  logic        g_ov  [3];

  int errors = 0;
  int checks = 0;

  int          dm    [3];
  int          dmode [3];
  int          m_ptr [3];
  bit          m_v   [3];
  logic [31:0] m_d   [3];
  int          m_c   [3];

  always #5 clk = ~clk;

  assign in_data4 = {word[3], word[2], word[1], word[0]};
  assign in_data3 = in_data4[95:0];

  assign g_rdy[0] = rdy0;
  assign g_rdy[1] = rdy1;
  assign g_rdy[2] = {1'b0, rdy2};
  assign g_od[0]  = od0;
  assign g_od[1]  = od1;
  assign g_od[2]  = od2;
  assign g_oc[0]  = oc0;
  assign g_oc[1]  = oc1;
  assign g_oc[2]  = oc2;
  assign g_ov[0]  = ov0;
  assign g_ov[1]  = ov1;
  assign g_ov[2]  = ov2;

  arb_mux #(.N(32), .M(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid), .in_ready(rdy0),
    .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(out_ready)
  );

  arb_mux #(.N(32), .M(4), .MODE(0)) u_fix4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid), .in_ready(rdy1),
    .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(out_ready)
  );

  arb_mux #(.N(32), .M(3), .MODE(1)) u_rr3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid[2:0]), .in_ready(rdy2),
    .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(out_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; compares at the following falling edge.
  task automatic cycle(input bit r, input logic [3:0] v, input bit rdy);
    int          g;
    int          start;
    int          idx;
    bit          load;
    logic [3:0]  er;
    rst       = r;
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < 4; i++) word[i] = $urandom;
    #4;
    for (int d = 0; d < 3; d++) begin
      load  = !m_v[d] || rdy;
      g     = -1;
      start = (dmode[d] == 1) ? m_ptr[d] : 0;
      if (!r) begin
        for (int k = 0; k < dm[d]; k++) begin
          idx = (start + k) % dm[d];
          if (g < 0 && v[idx]) g = idx;
        end
      end
      er = (g >= 0 && load && !r) ? 4'(1 << g) : 4'b0;
      check_eq($sformatf("in_ready[dut%0d]", d), 64'(g_rdy[d]), 64'(er));
      check_eq($sformatf("out_valid[dut%0d]", d), 64'(g_ov[d]), 64'(m_v[d]));
      check_eq($sformatf("out_data[dut%0d]", d), 64'(g_od[d]), 64'(m_d[d]));
      check_eq($sformatf("out_chan[dut%0d]", d), 64'(g_oc[d]), 64'(m_c[d]));
      if (r) begin
        m_v[d] = 1'b0; m_d[d] = '0; m_c[d] = 0; m_ptr[d] = 0;
      end else if (er != 4'b0) begin
        m_v[d]   = 1'b1;
        m_d[d]   = word[g];
        m_c[d]   = g;
        m_ptr[d] = (g + 1) % dm[d];
      end else if (rdy) begin
        m_v[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    dm    = '{4, 4, 3};
    dmode = '{1, 0, 1};
    for (int d = 0; d < 3; d++) begin
      m_ptr[d] = 0; m_v[d] = 1'b0; m_d[d] = '0; m_c[d] = 0;
    end
    rst       = 1'b1;
    in_valid  = 4'hf;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) word[i] = '0;
    @(posedge clk);
    #1;

    repeat (2) cycle(1'b1, 4'b1111, 1'b0);
    repeat (2) cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0100, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    repeat (8) cycle(1'b0, 4'b1111, 1'b1);
    repeat (3) cycle(1'b0, 4'b1010, 1'b1);
    repeat (2) cycle(1'b0, 4'b1000, 1'b1);
    cycle(1'b0, 4'b0011, 1'b1);
    repeat (5) cycle(1'b0, 4'b0011, 1'b0);
    repeat (3) cycle(1'b0, 4'b0011, 1'b1);
    repeat (2) cycle(1'b0, 4'b1111, 1'b1);
    cycle(1'b1, 4'b1111, 1'b1);
    repeat (5) cycle(1'b0, 4'b1111, 1'b1);

    repeat (400) begin
      cycle(($urandom % 50) == 0, 4'($urandom), ($urandom % 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
